sigmoid_act_pipe: RTL and testbench
===================================

// Module: sigmoid_act_pipe
// PURPOSE
//  Pipelined signed-input sigmoid activation unit; successor to the x>=0 sigmoid LUT ROM.
//  Takes signed fixed-point x and returns sigmoid(x) as unsigned Q8.8 in 16 bits.
//  Negative x is served by symmetry: sigmoid(-x) = 1 - sigmoid(x). |x| beyond the table is clamped.
//  Sits between the neuron accumulator and the next layer's input buffer, with a valid/ready handshake.
// PARAMETERS
//  IN_W       16                   input width, two's complement
//  IN_FRAC    8                    fractional bits of x
//  STEP_SHIFT 5                    LUT step = 2^(STEP_SHIFT-IN_FRAC); default step is 1/8
//  ADDR_W     6                    LUT address width
//  LUT_DEPTH  49                   entries; entry k = min(255, round(256*sigmoid(k*step)))
//  OUT_W      16                   output width, Q(OUT_W-8).8; only bits [7:0] carry nonzero data
//  LUT_FILE   "sigmoid_lut.hex"    $readmemh image, LUT_DEPTH lines, 8-bit values
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      x is valid
//  in_ready   out  1      unit accepts x this cycle
//  in_x       in   IN_W   signed input sample
//  out_valid  out  1      out_y is valid
//  out_ready  in   1      downstream accepts out_y
//  out_y      out  OUT_W  sigmoid(x), Q8.8
//  out_sat    out  1      sample was clamped (|x| index >= LUT_DEPTH-1)
// BEHAVIOUR
//  - Reset values: out_valid=0, out_y=0, out_sat=0, all stage-valid bits 0; in_ready=1 the cycle after reset.
//  - Pipeline has 3 stages and latency 3 cycles when not stalled; throughput 1 sample per cycle.
//    - S1: sign = x[IN_W-1]; mag = |x| taken as unsigned IN_W bits, so -2^(IN_W-1) gives 2^(IN_W-1) and does not overflow;
//      idx = mag >> STEP_SHIFT; frac = mag[STEP_SHIFT-1:0].
//    - S1 clamp: if idx >= LUT_DEPTH-1 then idx = LUT_DEPTH-1, frac = 0, sat = 1.
//    - S2: registered LUT read of lut[idx], and of lut[idx+1] when interpolation is built in (see CONFIGURATION).
//    - S3: p = lut value (interpolated if enabled). out_y = sign ? (256 - p) : p, zero-extended to OUT_W.
//  - Result ranges: x=0 gives 0x0080 for either sign path. Negative clamp gives 0x0001.
//  - Handshake uses a global stall: adv = ~out_valid | out_ready, and in_ready = adv.
//    - Input is accepted on in_valid & in_ready.
//    - When adv=0, every stage register (data and valid) holds.
//    - out_y and out_sat stay stable while out_valid=1 and out_ready=0.
//    - Bubbles (in_valid=0) propagate as stage-valid=0. Data registers may update under a bubble, but out_y holds while out_valid=0.
//  - Simultaneous accept and emit in one cycle is allowed and loses no sample.
//  - rst mid-operation flushes every in-flight sample; nothing partial is ever emitted.
//  - The LUT is loaded by $readmemh(LUT_FILE) at elaboration. Addresses >= LUT_DEPTH are unreachable because of the clamp.
//  - Arithmetic:
//    - 256 - p is computed in 9 bits (p <= 255, so the result is in 1..256).
//    - The interpolation product is 9-bit signed delta * STEP_SHIFT-bit frac, truncated by >> STEP_SHIFT (floor).
// CONFIGURATION
//  - Macro: SIGMOID_INTERP_EN.
//  - Defined: S2 also reads lut[idx+1]. S3 computes p = lut[idx] + ((lut[idx+1]-lut[idx])*frac >> STEP_SHIFT).
//    - Clamped samples have frac=0, so idx+1 is never read past the table.
//    - Latency is still 3.
//  - Undefined: p = lut[idx] (step approximation, low bits ignored). The second read port and the multiplier are not built.
// TESTING
//  - rst=1 for 2 cycles, then release -> out_valid=0, out_y=0, in_ready=1.
//  - in_x = 0x0000, 0x0020, 0xFFE0, out_ready=1 -> 3 cycles later out_y = 0x0080, 0x0088, 0x0078 back to back, out_sat=0.
//  - in_x = 0x7FFF then 0x8000 -> out_y = 0x00FF with out_sat=1, then out_y = 0x0001 with out_sat=1.
//  - in_x = 0x0010 (x = 1/16):
//    - SIGMOID_INTERP_EN defined -> out_y = 0x0084.
//    - SIGMOID_INTERP_EN undefined -> out_y = 0x0080.
//  - Stream 0x0000, 0x0020, 0x0040, 0x0060, hold out_ready=0 for 5 cycles, then 1:
//    - in_ready drops once the pipe is full; out_y holds at 0x0080.
//    - Outputs then drain in order as 0x80, 0x88, 0x90, 0x98 with no loss and no duplicates.
//  - Assert rst while 3 samples are in flight -> next cycle out_valid=0. A fresh input afterwards emits after exactly 3 cycles.

Source files
------------

// File: rtl/sigmoid_act_pipe.sv
// 3-stage signed sigmoid: |x| -> table index (S1), table read (S2), symmetry fold (S3).
// Optional linear interpolation between table entries when SIGMOID_INTERP_EN is defined.
module sigmoid_act_pipe #(
  parameter int IN_W       = 16,
  parameter int IN_FRAC    = 8,
  parameter int STEP_SHIFT = 5,
  parameter int ADDR_W     = 6,
  parameter int LUT_DEPTH  = 49,
  parameter int OUT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_y,
  output logic             out_sat
);
  localparam int STAGES = 3;
  // Table below is sampled at step 2^(STEP_SHIFT-IN_FRAC) = 1/8.
  localparam int unused_step_exp = STEP_SHIFT - IN_FRAC;

  // entry k = min(255, round(256*sigmoid(k/8))), k = 0..48; padded to the full address space
  localparam logic [0:63][7:0] LUT = {
    8'd128, 8'd136, 8'd144, 8'd152, 8'd159, 8'd167, 8'd174, 8'd181,
    8'd187, 8'd193, 8'd199, 8'd204, 8'd209, 8'd214, 8'd218, 8'd222,
    8'd225, 8'd229, 8'd232, 8'd234, 8'd237, 8'd239, 8'd241, 8'd242,
    8'd244, 8'd245, 8'd246, 8'd248, 8'd248, 8'd249, 8'd250, 8'd251,
    8'd251, 8'd252, 8'd252, 8'd253, 8'd253, 8'd254, 8'd254, 8'd254,
    8'd254, 8'd254, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255,
    8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255,
    8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255
  };

  typedef struct packed {
    logic                  sign;
    logic                  sat;
    logic [ADDR_W-1:0]     idx;
`ifdef SIGMOID_INTERP_EN
    logic [STEP_SHIFT-1:0] frac;
`endif
  } s1_t;

  typedef struct packed {
    logic                  sign;
    logic                  sat;
    logic [7:0]            lo;
`ifdef SIGMOID_INTERP_EN
    logic [7:0]            hi;
    logic [STEP_SHIFT-1:0] frac;
`endif
  } s2_t;

  logic [STAGES:1] vld_pipe;
  s1_t             s1, s1_n;
  s2_t             s2, s2_n;
  logic            adv, clamp;
  logic [IN_W-1:0] mag, idx_full;
  logic [7:0]      p;
  logic [8:0]      p9;

  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_pipe[STAGES];

  // Unsigned magnitude: -2^(IN_W-1) maps to 2^(IN_W-1) without overflow.
  assign mag      = in_x[IN_W-1] ? (~in_x + 1'b1) : in_x;
  assign idx_full = mag >> STEP_SHIFT;
  assign clamp    = idx_full >= IN_W'(LUT_DEPTH - 1);

  always_comb begin
    s1_n      = '0;
    s1_n.sign = in_x[IN_W-1];
    s1_n.sat  = clamp;
    s1_n.idx  = clamp ? ADDR_W'(LUT_DEPTH - 1) : idx_full[ADDR_W-1:0];
`ifdef SIGMOID_INTERP_EN
    s1_n.frac = clamp ? '0 : mag[STEP_SHIFT-1:0];
`endif
  end

  always_comb begin
    s2_n      = '0;
    s2_n.sign = s1.sign;
    s2_n.sat  = s1.sat;
    s2_n.lo   = LUT[s1.idx];
`ifdef SIGMOID_INTERP_EN
    s2_n.hi   = LUT[ADDR_W'(s1.idx + 1'b1)];
    s2_n.frac = s1.frac;
`endif
  end

`ifdef SIGMOID_INTERP_EN
  logic signed [8:0]            delta;
  logic signed [STEP_SHIFT+8:0] prod;
  assign delta = $signed({1'b0, s2.hi}) - $signed({1'b0, s2.lo});
  assign prod  = delta * $signed({1'b0, s2.frac});
  assign p     = s2.lo + 8'(prod >>> STEP_SHIFT);
`else
  // Step approximation: fractional bits of |x| do not contribute.
  logic unused_frac;
  assign unused_frac = ^mag[STEP_SHIFT-1:0];
  assign p           = s2.lo;
`endif

  assign p9 = s2.sign ? (9'd256 - {1'b0, p}) : {1'b0, p};

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      s1       <= '0;
      s2       <= '0;
      out_y    <= '0;
      out_sat  <= 1'b0;
    end else if (adv) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
      s1       <= s1_n;
      s2       <= s2_n;
      // out_y only moves on a real sample so it holds across bubbles
      if (vld_pipe[STAGES-1]) begin
        out_y   <= OUT_W'(p9);
        out_sat <= s2.sat;
      end
    end
  end
endmodule

// File: tb/tb_sigmoid_act_pipe.sv
// Bench for sigmoid_act_pipe: vector table through a scoreboard, plus stall, latency and flush sequences.
module tb_sigmoid_act_pipe;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, out_sat;
  logic [15:0] in_x, out_y;

  always #5 clk = ~clk;

  sigmoid_act_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_sat(out_sat)
  );

  typedef struct { logic [15:0] x; logic [15:0] y; logic sat; } vec_t;
  typedef struct { logic [15:0] y; logic sat; } exp_t;

  exp_t        sbq[$];
  vec_t        vecs[$];
  exp_t        cur_exp;
  int          tests = 0;
  int          fails = 0;
  logic        rnd_en = 1'b0;
  logic        stall_d;
  logic [15:0] held_y;
  logic        held_sat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Scoreboard: push on accept, pop and compare on emit, check hold under backpressure.
  initial begin : mon
    exp_t e;
    stall_d = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_d = 1'b0;
      end else begin
        if (stall_d) begin
          chk("hold_valid", 32'(out_valid), 32'(1));
          chk("hold_y", 32'(out_y), 32'(held_y));
          chk("hold_sat", 32'(out_sat), 32'(held_sat));
        end
        if (out_valid && out_ready) begin
          if (sbq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_output: got y=0x%0h with no sample pending", out_y);
          end else begin
            e = sbq.pop_front();
            chk("out_y", 32'(out_y), 32'(e.y));
            chk("out_sat", 32'(out_sat), 32'(e.sat));
          end
        end
        stall_d  = out_valid && !out_ready;
        held_y   = out_y;
        held_sat = out_sat;
        if (in_valid && in_ready) sbq.push_back(cur_exp);
      end
    end
  end

  initial begin : rnd_ready
    forever begin
      @(posedge clk);
      #1;
      if (rnd_en) out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic s);
    int   n = 0;
    logic acc;
    in_x        = x;
    cur_exp.y   = y;
    cur_exp.sat = s;
    in_valid    = 1'b1;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 100);
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: x=0x%0h not accepted, expected acceptance", x);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sbq.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, 32'(sbq.size()), 32'(0));
  endtask

  // Cycles from the accepting edge until out_valid, pipe assumed empty and out_ready=1.
  task automatic latency(input string name, input logic [15:0] x, input logic [15:0] y);
    int n = 1;
    send(x, y, 1'b0);
    while (!out_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, 32'(n), 32'(3));
  endtask

  initial begin : main
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_x        = '0;
    out_ready   = 1'b1;
    cur_exp.y   = '0;
    cur_exp.sat = 1'b0;

    vecs.push_back('{16'h0000, 16'h0080, 1'b0});
    vecs.push_back('{16'h0020, 16'h0088, 1'b0});
    vecs.push_back('{16'hFFE0, 16'h0078, 1'b0});
    vecs.push_back('{16'h7FFF, 16'h00FF, 1'b1});
    vecs.push_back('{16'h8000, 16'h0001, 1'b1});
    vecs.push_back('{16'h0040, 16'h0090, 1'b0});
    vecs.push_back('{16'h0060, 16'h0098, 1'b0});
    vecs.push_back('{16'hFFC0, 16'h0070, 1'b0});
    vecs.push_back('{16'h0100, 16'h00BB, 1'b0});
    vecs.push_back('{16'hFF00, 16'h0045, 1'b0});
    vecs.push_back('{16'h05E0, 16'h00FF, 1'b0});
    vecs.push_back('{16'hFA20, 16'h0001, 1'b0});
    vecs.push_back('{16'h0600, 16'h00FF, 1'b1});
    vecs.push_back('{16'hFA00, 16'h0001, 1'b1});
    vecs.push_back('{16'hFFFF, 16'h0080, 1'b0});
`ifdef SIGMOID_INTERP_EN
    vecs.push_back('{16'h0010, 16'h0084, 1'b0});
    vecs.push_back('{16'hFFF0, 16'h007C, 1'b0});
    vecs.push_back('{16'h0030, 16'h008C, 1'b0});
    vecs.push_back('{16'h0018, 16'h0086, 1'b0});
`else
    vecs.push_back('{16'h0010, 16'h0080, 1'b0});
    vecs.push_back('{16'hFFF0, 16'h0080, 1'b0});
    vecs.push_back('{16'h0030, 16'h0088, 1'b0});
    vecs.push_back('{16'h0018, 16'h0080, 1'b0});
`endif

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_y", 32'(out_y), 32'(0));
    chk("rst_out_sat", 32'(out_sat), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(1));

    latency("latency_first", 16'h0000, 16'h0080);
    drain("drain_first");

    foreach (vecs[i]) send(vecs[i].x, vecs[i].y, vecs[i].sat);
    drain("drain_table");

    rnd_en = 1'b1;
    foreach (vecs[i]) send(vecs[i].x, vecs[i].y, vecs[i].sat);
    drain("drain_random_ready");
    rnd_en    = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Fill the pipe under backpressure, then release.
    out_ready = 1'b0;
    send(16'h0000, 16'h0080, 1'b0);
    send(16'h0020, 16'h0088, 1'b0);
    send(16'h0040, 16'h0090, 1'b0);
    in_x        = 16'h0060;
    cur_exp.y   = 16'h0098;
    cur_exp.sat = 1'b0;
    in_valid    = 1'b1;
    repeat (5) begin
      chk("stall_in_ready", 32'(in_ready), 32'(0));
      chk("stall_out_y", 32'(out_y), 32'(16'h0080));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain("drain_stall");

    // Flush three in-flight samples with reset.
    out_ready = 1'b0;
    send(16'h0100, 16'h00BB, 1'b0);
    send(16'h7FFF, 16'h00FF, 1'b1);
    send(16'hFFE0, 16'h0078, 1'b0);
    rst = 1'b1;
    sbq.delete();
    @(posedge clk);
    #1;
    chk("flush_out_valid", 32'(out_valid), 32'(0));
    rst       = 1'b0;
    out_ready = 1'b1;
    chk("flush_in_ready", 32'(in_ready), 32'(1));
    latency("latency_after_flush", 16'hFF00, 16'h0045);
    drain("drain_flush");
    repeat (5) @(posedge clk);
    #1;
    chk("final_idle_valid", 32'(out_valid), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "timeout");
  end
endmodule
